// File: rtl/rx_sync_if.sv
// Handshake bundle between the TX half, rx_sync and the downstream consumer.
// The master side is the TX half plus the consumer; rx_sync is the slave.
interface rx_sync_if #(
    parameter int unsigned WIDTH   = 8,
    parameter int unsigned COUNT_W = 16
);
    logic               tx;
    logic [WIDTH-1:0]   data;
    logic               rx_a;
    logic [WIDTH-1:0]   out;
    logic               out_valid;
    logic               out_ready;
    logic [COUNT_W-1:0] rx_count;

    modport master (
        output tx, data, out_ready,
        input  rx_a, out, out_valid, rx_count
    );

    modport slave (
        input  tx, data, out_ready,
        output rx_a, out, out_valid, rx_count
    );
endinterface

// File: rtl/rx_sync.sv
// Receive half of a toggle-handshake clock-domain crossing: captures the TX word
// when the synchronised request toggles, then offers it downstream via valid/ready.
module rx_sync #(
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned EARLY_ACK = 1,
    parameter int unsigned COUNT_W   = 16
) (
    input  logic     clk,
    input  logic     rst,
    rx_sync_if.slave bus
);
    localparam bit early_ack_en = (EARLY_ACK != 0);

    typedef enum logic {
        S_EMPTY = 1'b0,
        S_FULL  = 1'b1
    } state_e;

    state_e             state_q;
    logic               tx1_q;
    logic               tx2_q;
    logic               seen_q;
    logic               rx_a_q;
    logic [WIDTH-1:0]   out_q;
    logic [COUNT_W-1:0] count_q;
    logic               pending_c;

    // A request is outstanding whenever the synchronised toggle differs from the last one taken.
    assign pending_c = tx2_q ^ seen_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_EMPTY;
            tx1_q   <= 1'b0;
            tx2_q   <= 1'b0;
            seen_q  <= 1'b0;
            rx_a_q  <= 1'b0;
            out_q   <= '0;
            count_q <= '0;
        end else begin
            tx1_q <= bus.tx;
            tx2_q <= tx1_q;
            case (state_q)
                S_EMPTY: begin
                    if (pending_c) begin
                        out_q   <= bus.data;
                        seen_q  <= ~seen_q;
                        count_q <= count_q + COUNT_W'(1);
                        state_q <= S_FULL;
                        if (early_ack_en) begin
                            rx_a_q <= ~rx_a_q;
                        end
                    end
                end
                S_FULL: begin
                    if (bus.out_ready) begin
                        if (early_ack_en && pending_c) begin
                            // Consume and reload on the same edge keeps the stream bubble-free.
                            out_q   <= bus.data;
                            seen_q  <= ~seen_q;
                            rx_a_q  <= ~rx_a_q;
                            count_q <= count_q + COUNT_W'(1);
                        end else begin
                            state_q <= S_EMPTY;
                            if (!early_ack_en) begin
                                rx_a_q <= ~rx_a_q;
                            end
                        end
                    end
                end
                default: state_q <= S_EMPTY;
            endcase
        end
    end

    assign bus.rx_a      = rx_a_q;
    assign bus.out       = out_q;
    assign bus.out_valid = (state_q == S_FULL);
    assign bus.rx_count  = count_q;
endmodule
